clock_sel_ctrl: RTL and testbench

// - Sequenced, glitch-safe controller for the target clock mux and clock-out gating, in the usb_clk domain.
// - Generalises the crypto-clock select: NUM_SRC selectable sources, NUM_OUT gated outputs, register or DIP mode.
// - Also adds source-valid checking and a gate/switch/ungate sequence.
// - Drives the S pin of the BUFGMUX tree and the CE pins of the output ODDRs; holds no clock paths itself.

---
 rtl/clock_sel_pkg.sv | 18 +
 rtl/clksel_sync_debounce.sv | 57 +++++
 rtl/clock_sel_ctrl.sv | 169 ++++++++++++++++
 tb/tb_clock_sel_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_sel_pkg.sv
// Shared types and helpers for the clock-select controller: FSM states,
// settle-counter sizing and the switch-counter saturation value.
package clock_sel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        SWITCH = 2'd2
    } clksel_state_e;

    localparam logic [7:0] SWITCH_CNT_MAX = 8'd255;

    // Width needed to count 0 .. cycles-1.
    function automatic int settle_cnt_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/clksel_sync_debounce.sv
// Two-flop synchroniser for one asynchronous level, with an optional
// debounce stage that accepts a value only after a run of equal samples.
module clksel_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter bit USE_DEBOUNCE    = 1'b0
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    generate
        if (USE_DEBOUNCE && (DEBOUNCE_CYCLES > 0)) begin : g_debounce
            localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] r_cnt;
            logic          r_last;
            logic          r_stable;

            // r_cnt holds (number of consecutive equal samples - 1)
            always_ff @(posedge clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt    <= '0;
                    r_last   <= 1'b0;
                    r_stable <= 1'b0;
                end else if (r_sync != r_last) begin
                    r_last <= r_sync;
                    r_cnt  <= '0;
                end else if (r_cnt == LAST) begin
                    r_stable <= r_last;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign o_level = r_stable;
        end else begin : g_direct
            assign o_level = r_sync;
        end
    endgenerate

endmodule

// File: rtl/clock_sel_ctrl.sv
// Sequenced gate/switch/ungate controller for the clock mux select and output enables.
// Optional DIP debounce is enabled by defining CLKSEL_DIP_DEBOUNCE_EN.
module clock_sel_ctrl
    import clock_sel_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int SRC_W           = $clog2(NUM_SRC),
    parameter int NUM_OUT         = 2,
    parameter int DEFAULT_SRC     = 0,
    parameter int SETTLE_CYCLES   = 8,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic               usb_clk,
    input  logic               I_rst_n,
    input  logic               I_reg_mode,
    input  logic [SRC_W-1:0]   I_reg_src,
    input  logic [NUM_OUT-1:0] I_reg_out_en,
    input  logic [SRC_W-1:0]   I_dip_src,
    input  logic [NUM_OUT-1:0] I_dip_out_en,
    input  logic [NUM_SRC-1:0] I_src_valid,
    input  logic               I_err_clr,
    output logic [SRC_W-1:0]   O_mux_sel,
    output logic [NUM_OUT-1:0] O_out_en,
    output logic               O_busy,
    output logic               O_err_invalid,
    output logic [7:0]         O_switch_cnt
);

`ifdef CLKSEL_DIP_DEBOUNCE_EN
    localparam bit DIP_DEBOUNCE = 1'b1;
`else
    localparam bit DIP_DEBOUNCE = 1'b0;
`endif

    localparam int               CNT_W       = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [SRC_W-1:0]   w_dip_src;
    logic [NUM_OUT-1:0] w_dip_out_en;
    logic [NUM_SRC-1:0] w_valid;

    genvar gi;
    generate
        for (gi = 0; gi < SRC_W; gi++) begin : g_dip_src
            clksel_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .USE_DEBOUNCE(DIP_DEBOUNCE)) u_sync (
                .clk(usb_clk), .i_rst_n(I_rst_n), .i_async(I_dip_src[gi]), .o_level(w_dip_src[gi]));
        end
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_dip_en
            clksel_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .USE_DEBOUNCE(DIP_DEBOUNCE)) u_sync (
                .clk(usb_clk), .i_rst_n(I_rst_n), .i_async(I_dip_out_en[gi]), .o_level(w_dip_out_en[gi]));
        end
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_valid
            clksel_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .USE_DEBOUNCE(1'b0)) u_sync (
                .clk(usb_clk), .i_rst_n(I_rst_n), .i_async(I_src_valid[gi]), .o_level(w_valid[gi]));
        end
    endgenerate

    logic [SRC_W-1:0]   r_req_src,    w_req_src_next;
    logic [NUM_OUT-1:0] r_req_en,     w_req_en_next;
    clksel_state_e      r_state,      w_state_next;
    logic [CNT_W-1:0]   r_cnt,        w_cnt_next;
    logic [SRC_W-1:0]   r_tgt,        w_tgt_next;
    logic [SRC_W-1:0]   r_mux_sel,    w_mux_sel_next;
    logic [NUM_OUT-1:0] r_out_en,     w_out_en_next;
    logic               r_busy,       w_busy_next;
    logic               r_err,        w_err_next;
    logic [7:0]         r_switch_cnt, w_switch_cnt_next;
    logic               w_req_ok;
    logic               w_tgt_ok;

    assign w_req_src_next = I_reg_mode ? I_reg_src    : w_dip_src;
    assign w_req_en_next  = I_reg_mode ? I_reg_out_en : w_dip_out_en;

    // Out-of-range selects never match a loop index, so they read as invalid.
    always_comb begin
        w_req_ok = 1'b0;
        w_tgt_ok = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_req_src == SRC_W'(i)) w_req_ok = w_valid[i];
            if (r_tgt == SRC_W'(i))     w_tgt_ok = w_valid[i];
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_tgt_next        = r_tgt;
        w_mux_sel_next    = r_mux_sel;
        w_out_en_next     = r_out_en;
        w_busy_next       = r_busy;
        w_err_next        = r_err & ~I_err_clr;
        w_switch_cnt_next = r_switch_cnt;
        case (r_state)
            IDLE: begin
                w_out_en_next = r_req_en;
                if (r_req_src != r_mux_sel) begin
                    if (!w_req_ok) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_tgt_next    = r_req_src;
                        w_out_en_next = '0;
                        w_busy_next   = 1'b1;
                        w_cnt_next    = '0;
                        w_state_next  = GATE;
                    end
                end
            end
            GATE: begin
                // Target vanished before the mux moved: back out without switching.
                if (!w_tgt_ok) begin
                    w_out_en_next = r_req_en;
                    w_busy_next   = 1'b0;
                    w_err_next    = 1'b1;
                    w_state_next  = IDLE;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_mux_sel_next = r_tgt;
                    w_cnt_next     = '0;
                    w_state_next   = SWITCH;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            SWITCH: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_out_en_next = r_req_en;
                    w_busy_next   = 1'b0;
                    if (r_switch_cnt != SWITCH_CNT_MAX) w_switch_cnt_next = r_switch_cnt + 8'd1;
                    w_state_next  = IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge usb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_req_src    <= SRC_W'(DEFAULT_SRC);
            r_req_en     <= '0;
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_tgt        <= SRC_W'(DEFAULT_SRC);
            r_mux_sel    <= SRC_W'(DEFAULT_SRC);
            r_out_en     <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_switch_cnt <= '0;
        end else begin
            r_req_src    <= w_req_src_next;
            r_req_en     <= w_req_en_next;
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_tgt        <= w_tgt_next;
            r_mux_sel    <= w_mux_sel_next;
            r_out_en     <= w_out_en_next;
            r_busy       <= w_busy_next;
            r_err        <= w_err_next;
            r_switch_cnt <= w_switch_cnt_next;
        end
    end

    assign O_mux_sel     = r_mux_sel;
    assign O_out_en      = r_out_en;
    assign O_busy        = r_busy;
    assign O_err_invalid = r_err;
    assign O_switch_cnt  = r_switch_cnt;

endmodule

// File: tb/tb_clock_sel_ctrl.sv
// Self-checking bench for clock_sel_ctrl: directed request table, randomized requests
// against a transaction-level timing model, and hand-written corner sequences.
module tb_clock_sel_ctrl;

    localparam int SETTLE = 8;
    localparam int DEB    = 16;

    logic       usb_clk = 1'b0;
    logic       I_rst_n;
    logic       I_reg_mode;
    logic [1:0] I_reg_src;
    logic [1:0] I_reg_out_en;
    logic [1:0] I_dip_src;
    logic [1:0] I_dip_out_en;
    logic [3:0] I_src_valid;
    logic       I_err_clr;
    logic [1:0] O_mux_sel;
    logic [1:0] O_out_en;
    logic       O_busy;
    logic       O_err_invalid;
    logic [7:0] O_switch_cnt;

    always #5 usb_clk = ~usb_clk;

    clock_sel_ctrl #(
        .NUM_SRC(4), .NUM_OUT(2), .DEFAULT_SRC(0),
        .SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .usb_clk(usb_clk), .I_rst_n(I_rst_n), .I_reg_mode(I_reg_mode),
        .I_reg_src(I_reg_src), .I_reg_out_en(I_reg_out_en),
        .I_dip_src(I_dip_src), .I_dip_out_en(I_dip_out_en),
        .I_src_valid(I_src_valid), .I_err_clr(I_err_clr),
        .O_mux_sel(O_mux_sel), .O_out_en(O_out_en), .O_busy(O_busy),
        .O_err_invalid(O_err_invalid), .O_switch_cnt(O_switch_cnt)
    );

    typedef struct {
        logic [1:0] src;
        logic [1:0] en;
        logic [3:0] valid;
        bit         sw;
        bit         err;
        logic [1:0] mux;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs [6];
    int   checks    = 0;
    int   failures  = 0;
    int   cur_mux   = 0;
    int   model_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge usb_clk);
        #1;
    endtask

    function automatic int sat_inc(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    // One register-mode request; edge k is the edge just before the request changes.
    task automatic run_req(input logic [1:0] src, input logic [1:0] en, input logic [3:0] valid,
                           input bit exp_sw, input bit exp_err, input logic [1:0] exp_mux,
                           input logic [7:0] exp_cnt);
        I_src_valid = valid;
        tick(4);
        I_reg_src    = src;
        I_reg_out_en = en;
        tick(2);
        if (exp_sw) begin
            check("busy_k2", 32'(O_busy), 1);
            check("gated_k2", 32'(O_out_en), 0);
            tick(7);
            check("mux_k9", 32'(O_mux_sel), 32'(cur_mux));
            tick(1);
            check("mux_k10", 32'(O_mux_sel), 32'(exp_mux));
            tick(7);
            check("busy_k17", 32'(O_busy), 1);
            tick(1);
            check("busy_k18", 32'(O_busy), 0);
            check("out_en_k18", 32'(O_out_en), 32'(en));
        end else begin
            check("busy_nosw", 32'(O_busy), 0);
            check("out_en_nosw", 32'(O_out_en), 32'(en));
            tick(8);
            check("mux_nosw", 32'(O_mux_sel), 32'(exp_mux));
            check("out_en_hold", 32'(O_out_en), 32'(en));
        end
        check("err", 32'(O_err_invalid), 32'(exp_err));
        check("switch_cnt", 32'(O_switch_cnt), 32'(exp_cnt));
        $display("req src=%0d en=%0d valid=%h -> mux=%0d busy=%0d err=%0d cnt=%0d",
                 src, en, valid, O_mux_sel, O_busy, O_err_invalid, O_switch_cnt);
        I_reg_src = exp_mux;
        tick(3);
        I_err_clr = 1'b1;
        tick(1);
        I_err_clr = 1'b0;
        check("err_cleared", 32'(O_err_invalid), 0);
    endtask

    // Model: a request differing from the current source switches if valid, else errors.
    task automatic model_req(input logic [1:0] src, input logic [1:0] en, input logic [3:0] valid);
        bit sw, er;
        int nmux, ncnt;
        sw   = (int'(src) != cur_mux) && valid[src];
        er   = (int'(src) != cur_mux) && !valid[src];
        nmux = sw ? int'(src) : cur_mux;
        ncnt = sw ? sat_inc(model_cnt) : model_cnt;
        run_req(src, en, valid, sw, er, 2'(nmux), 8'(ncnt));
        cur_mux   = nmux;
        model_cnt = ncnt;
    endtask

    initial begin
        logic [1:0] t1, t2;
        bit seen;

        vecs[0] = '{2'd2, 2'b11, 4'hF,    1'b1, 1'b0, 2'd2, 8'd1};
        vecs[1] = '{2'd3, 2'b01, 4'b0111, 1'b0, 1'b1, 2'd2, 8'd1};
        vecs[2] = '{2'd2, 2'b10, 4'hF,    1'b0, 1'b0, 2'd2, 8'd1};
        vecs[3] = '{2'd0, 2'b11, 4'b0001, 1'b1, 1'b0, 2'd0, 8'd2};
        vecs[4] = '{2'd1, 2'b00, 4'b1101, 1'b0, 1'b1, 2'd0, 8'd2};
        vecs[5] = '{2'd3, 2'b10, 4'b1000, 1'b1, 1'b0, 2'd3, 8'd3};

        I_rst_n = 1'b0; I_reg_mode = 1'b1; I_reg_src = 2'd0; I_reg_out_en = 2'b11;
        I_dip_src = 2'd0; I_dip_out_en = 2'b11; I_src_valid = 4'hF; I_err_clr = 1'b0;
        tick(3);
        check("rst_mux", 32'(O_mux_sel), 0);
        check("rst_out_en", 32'(O_out_en), 0);
        check("rst_busy", 32'(O_busy), 0);
        check("rst_err", 32'(O_err_invalid), 0);
        check("rst_cnt", 32'(O_switch_cnt), 0);
        I_rst_n = 1'b1;
        tick(4);

        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i].src, vecs[i].en, vecs[i].valid, vecs[i].sw, vecs[i].err, vecs[i].mux, vecs[i].cnt);
            cur_mux   = int'(vecs[i].mux);
            model_cnt = int'(vecs[i].cnt);
        end

        // New request during GATE is held off until the first switch completes.
        I_src_valid = 4'hF;
        tick(4);
        t1 = 2'(cur_mux + 1);
        t2 = 2'(cur_mux + 3);
        I_reg_src = t1; I_reg_out_en = 2'b01;
        tick(5);
        I_reg_src = t2;
        tick(13);
        check("seq1_busy_k18", 32'(O_busy), 0);
        check("seq1_mux_k18", 32'(O_mux_sel), 32'(t1));
        check("seq1_cnt", 32'(O_switch_cnt), 32'(sat_inc(model_cnt)));
        tick(1);
        check("seq2_busy_k19", 32'(O_busy), 1);
        tick(16);
        check("seq2_busy_k35", 32'(O_busy), 0);
        check("seq2_mux", 32'(O_mux_sel), 32'(t2));
        check("seq2_out_en", 32'(O_out_en), 1);
        check("seq2_cnt", 32'(O_switch_cnt), 32'(sat_inc(sat_inc(model_cnt))));
        $display("req back-to-back %0d then %0d -> mux=%0d cnt=%0d", t1, t2, O_mux_sel, O_switch_cnt);
        cur_mux   = int'(t2);
        model_cnt = sat_inc(sat_inc(model_cnt));

        // Target loses valid during GATE: abort without moving the mux.
        tick(2);
        t1 = 2'(cur_mux + 1);
        I_reg_src = t1; I_reg_out_en = 2'b10;
        tick(3);
        I_src_valid[t1] = 1'b0;
        tick(5);
        check("abort_busy", 32'(O_busy), 0);
        check("abort_mux", 32'(O_mux_sel), 32'(cur_mux));
        check("abort_err", 32'(O_err_invalid), 1);
        check("abort_out_en", 32'(O_out_en), 2);
        tick(4);
        check("abort_mux_late", 32'(O_mux_sel), 32'(cur_mux));
        I_err_clr = 1'b1;
        tick(1);
        I_err_clr = 1'b0;
        check("err_new_wins", 32'(O_err_invalid), 1);
        $display("req abort src=%0d -> mux=%0d err=%0d", t1, O_mux_sel, O_err_invalid);
        I_src_valid = 4'hF; I_reg_src = 2'(cur_mux);
        tick(5);
        I_err_clr = 1'b1;
        tick(1);
        I_err_clr = 1'b0;
        check("abort_err_cleared", 32'(O_err_invalid), 0);

        for (int i = 0; i < 30; i++) begin
            model_req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom));
        end

        while (model_cnt < 255) begin
            model_req((cur_mux == 0) ? 2'd1 : 2'd0, 2'b11, 4'hF);
        end
        model_req((cur_mux == 0) ? 2'd1 : 2'd0, 2'b01, 4'hF);
        check("cnt_saturated", 32'(O_switch_cnt), 255);

        // Reset in the middle of SWITCH.
        t1 = 2'(cur_mux + 1);
        I_reg_src = t1; I_reg_out_en = 2'b11;
        tick(12);
        I_reg_src = 2'd0;
        I_rst_n = 1'b0;
        #1;
        check("midrst_mux", 32'(O_mux_sel), 0);
        check("midrst_out_en", 32'(O_out_en), 0);
        check("midrst_busy", 32'(O_busy), 0);
        check("midrst_cnt", 32'(O_switch_cnt), 0);
        tick(2);
        I_rst_n = 1'b1;
        tick(6);
        check("postrst_mux", 32'(O_mux_sel), 0);
        check("postrst_busy", 32'(O_busy), 0);
        check("postrst_out_en", 32'(O_out_en), 3);
        $display("req reset mid-switch -> mux=%0d busy=%0d", O_mux_sel, O_busy);
        cur_mux = 0; model_cnt = 0;

        // DIP mode.
        I_dip_src = 2'd0; I_dip_out_en = 2'b11; I_reg_mode = 1'b0;
        tick(25);
        check("dip_idle_mux", 32'(O_mux_sel), 0);
        check("dip_idle_out_en", 32'(O_out_en), 3);
`ifdef CLKSEL_DIP_DEBOUNCE_EN
        I_dip_src = 2'd1;
        tick(5);
        I_dip_src = 2'd0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (O_busy) seen = 1'b1;
        end
        check("dip_glitch_ignored", 32'(seen), 0);
        check("dip_glitch_mux", 32'(O_mux_sel), 0);
`endif
        I_dip_src = 2'd2;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick(1);
            if (O_busy) seen = 1'b1;
        end
        check("dip_busy_seen", 32'(seen), 1);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick(1);
            if (!O_busy) seen = 1'b1;
        end
        check("dip_done", 32'(seen), 1);
        check("dip_mux", 32'(O_mux_sel), 2);
        check("dip_out_en", 32'(O_out_en), 3);
        check("dip_cnt", 32'(O_switch_cnt), 1);
        $display("req dip src=2 -> mux=%0d cnt=%0d", O_mux_sel, O_switch_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
